// File: rtl/pulse_sync_mc_if.sv
// Bundle of per-channel event inputs and pulse/status outputs for pulse_sync_mc.
// master: the side that produces events and consumes pulses. slave: the receiver.
interface pulse_sync_mc_if #(
    parameter int unsigned CH = 4
);
    logic [CH-1:0] i_a_sig;
    logic [CH-1:0] i_clr;
    logic [CH-1:0] o_pulse;
    logic [CH-1:0] o_busy;
    logic [CH-1:0] o_ovf;
    logic [CH-1:0] o_sync_lvl;

    modport master (
        output i_a_sig,
        output i_clr,
        input  o_pulse,
        input  o_busy,
        input  o_ovf,
        input  o_sync_lvl
    );

    modport slave (
        input  i_a_sig,
        input  i_clr,
        output o_pulse,
        output o_busy,
        output o_ovf,
        output o_sync_lvl
    );
endinterface

// File: rtl/pulse_sync_mc.sv
// Multi-channel asynchronous event receiver. Each channel synchronises a foreign-domain
// level, detects the selected edge(s) and emits a fixed-width pulse per event. Events that
// arrive while a pulse is in flight are queued in a saturating pending counter.
module pulse_sync_mc #(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = 0,
    parameter int unsigned PULSE_W     = 1,
    parameter int unsigned PEND_W      = 3
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    pulse_sync_mc_if.slave bus_if
);

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StGap
    } state_e;

    localparam int unsigned       CntW    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [CntW-1:0]   CntLoad = CntW'(PULSE_W - 1);
    localparam logic [CntW-1:0]   CntOne  = CntW'(1);
    localparam logic [PEND_W-1:0] PendMax = '1;
    localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_hist;
        state_e                 r_state;
        state_e                 w_state_nxt;
        logic [CntW-1:0]        r_cnt;
        logic [CntW-1:0]        w_cnt_nxt;
        logic [PEND_W-1:0]      r_pend;
        logic [PEND_W-1:0]      w_pend_nxt;
        logic [PEND_W-1:0]      w_pend_base;
        logic                   r_ovf;
        logic                   w_ovf_nxt;
        logic                   w_ovf_base;
        logic                   w_sync_out;
        logic                   w_rise;
        logic                   w_fall;
        logic                   w_event;

        assign w_sync_out = r_sync[SYNC_STAGES-1];
        assign w_rise     = w_sync_out & ~r_hist;
        assign w_fall     = ~w_sync_out & r_hist;
        assign w_event    = (EDGE_MODE == 0) ? w_rise :
                            (EDGE_MODE == 1) ? w_fall : (w_rise | w_fall);

        // Clear takes effect first so a same-cycle event lands on an empty queue.
        assign w_pend_base = bus_if.i_clr[g] ? '0 : r_pend;
        assign w_ovf_base  = bus_if.i_clr[g] ? 1'b0 : r_ovf;

        // Synchroniser chain and edge-history flop.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_sync <= '0;
                r_hist <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], bus_if.i_a_sig[g]};
                r_hist <= w_sync_out;
            end
        end

        // Channel FSM, pulse counter, pending queue and sticky overflow state.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_state <= StIdle;
                r_cnt   <= '0;
                r_pend  <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_pend  <= w_pend_nxt;
                r_ovf   <= w_ovf_nxt;
            end
        end

        // Next-state: start/extend pulses, queue or drop events, dequeue in the gap cycle.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_pend_nxt  = w_pend_base;
            w_ovf_nxt   = w_ovf_base;
            unique case (r_state)
                StIdle: begin
                    if (w_event) begin
                        w_state_nxt = StPulse;
                        w_cnt_nxt   = CntLoad;
                    end else if (w_pend_base != '0) begin
                        // Only reachable when a clear raced an event in the gap cycle.
                        w_state_nxt = StPulse;
                        w_cnt_nxt   = CntLoad;
                        w_pend_nxt  = w_pend_base - PendOne;
                    end
                end
                StPulse: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = StGap;
                    end else begin
                        w_cnt_nxt = r_cnt - CntOne;
                    end
                    if (w_event) begin
                        if (w_pend_base == PendMax) begin
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_pend_nxt = w_pend_base + PendOne;
                        end
                    end
                end
                StGap: begin
                    if (w_pend_base != '0) begin
                        w_state_nxt = StPulse;
                        w_cnt_nxt   = CntLoad;
                        // A same-cycle event replaces the dequeued slot: net zero.
                        if (!w_event) begin
                            w_pend_nxt = w_pend_base - PendOne;
                        end
                    end else begin
                        w_state_nxt = StIdle;
                        if (w_event) begin
                            w_pend_nxt = w_pend_base + PendOne;
                        end
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end

        assign bus_if.o_pulse[g]    = (r_state == StPulse);
        assign bus_if.o_busy[g]     = (r_state != StIdle) | (r_pend != '0);
        assign bus_if.o_ovf[g]      = r_ovf;
        assign bus_if.o_sync_lvl[g] = w_sync_out;
    end

endmodule

// File: tb/tb_pulse_sync_mc.sv
// Directed bench for pulse_sync_mc. Three instances cover rising-edge queueing (PULSE_W=8),
// both-edge mode with short pulses (PULSE_W=3) and pending saturation (PULSE_W=64).
// Expected pulses (lane, start cycle, width) are queued when stimulus is driven and
// matched by a monitor when each pulse ends. Lanes 0-3: u_dut0, 4-7: u_dut1, 8: u_dut2.
module tb_pulse_sync_mc;

    typedef struct packed {
        int lane;
        int start;
        int width;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   t;
    exp_t exp_q[$];

    logic [8:0] mon_pulse;
    logic [8:0] mon_prev = '0;
    int         mon_start[9];
    int         mon_width[9];

    pulse_sync_mc_if #(.CH(4)) if0 ();
    pulse_sync_mc_if #(.CH(4)) if1 ();
    pulse_sync_mc_if #(.CH(1)) if2 ();

    pulse_sync_mc #(
        .CH(4), .SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_W(8), .PEND_W(3)
    ) u_dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_if  (if0)
    );

    pulse_sync_mc #(
        .CH(4), .SYNC_STAGES(2), .EDGE_MODE(2), .PULSE_W(3), .PEND_W(3)
    ) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_if  (if1)
    );

    pulse_sync_mc #(
        .CH(1), .SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_W(64), .PEND_W(3)
    ) u_dut2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_if  (if2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mon_pulse = {if2.o_pulse, if1.o_pulse, if0.o_pulse};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_pulse(input int lane, input int start, input int width);
        exp_t e;
        e.lane  = lane;
        e.start = start;
        e.width = width;
        exp_q.push_back(e);
    endtask

    task automatic lane_done(input int lane, input int start, input int width);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].lane == lane) begin
                idx = i;
                break;
            end
        end
        tests++;
        assert (idx >= 0) else begin
            fails++;
            $error("FAIL pulse_unexpected lane %0d: observed start %0d width %0d, expected none",
                   lane, start, width);
        end
        if (idx >= 0) begin
            check($sformatf("pulse_start_l%0d", lane), start, exp_q[idx].start);
            check($sformatf("pulse_width_l%0d", lane), width, exp_q[idx].width);
            exp_q.delete(idx);
        end
    endtask

    // Measures every pulse on every lane and hands it to the scoreboard when it ends.
    always @(negedge clk) begin
        for (int b = 0; b < 9; b++) begin
            if (mon_pulse[b]) begin
                if (!mon_prev[b]) begin
                    mon_start[b] <= cyc;
                    mon_width[b] <= 1;
                end else begin
                    mon_width[b] <= mon_width[b] + 1;
                end
            end else if (mon_prev[b]) begin
                lane_done(b, mon_start[b], mon_width[b]);
            end
        end
        mon_prev <= mon_pulse;
    end

    // Inputs change 2 ns after a rising edge, so a drive at cycle c is captured at c+1.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic tap0(input int off);
        step(t + off - cyc);
        if0.i_a_sig[0] = 1'b1;
        step(2);
        if0.i_a_sig[0] = 1'b0;
    endtask

    initial begin
        int cnt;
        int offs[5];
        offs[0] = 0; offs[1] = 4; offs[2] = 8; offs[3] = 12; offs[4] = 18;
        rst_n       = 1'b0;
        if0.i_a_sig = 4'hF;
        if0.i_clr   = '0;
        if1.i_a_sig = '0;
        if1.i_clr   = '0;
        if2.i_a_sig = '0;
        if2.i_clr   = '0;

        // Reset: inputs high, outputs held low.
        step(3);
        check("rst_pulse", if0.o_pulse, 0);
        check("rst_busy", if0.o_busy, 0);
        check("rst_ovf", if0.o_ovf, 0);
        check("rst_sync_lvl", if0.o_sync_lvl, 0);
        check("rst_busy_dut2", if2.o_busy, 0);
        rst_n = 1'b1;
        t = cyc;
        for (int c = 0; c < 4; c++) expect_pulse(c, t + 3, 8);
        step(2);
        check("rel_sync_lvl", if0.o_sync_lvl, 15);
        check("rel_busy_pre", if0.o_busy, 0);
        step(1);
        check("rel_busy", if0.o_busy, 15);
        step(12);
        check("rel_idle", if0.o_busy, 0);
        if0.i_a_sig = 4'h0;
        step(4);

        // Queueing: 5 rising edges 4 cycles apart, pulses every 9 cycles.
        t = cyc;
        for (int k = 0; k < 5; k++) expect_pulse(0, t + 3 + 9 * k, 8);
        for (int k = 0; k < 5; k++) tap0(4 * k);
        step(30);
        check("queue_ovf", if0.o_ovf, 0);
        check("queue_idle", if0.o_busy, 0);

        // Event in the gap cycle with pending=2: pending unchanged, 5 pulses total.
        t = cyc;
        for (int k = 0; k < 5; k++) expect_pulse(0, t + 3 + 9 * k, 8);
        for (int k = 0; k < 5; k++) tap0(offs[k]);
        step(30);
        check("gap_evt_ovf", if0.o_ovf, 0);
        check("gap_evt_idle", if0.o_busy, 0);

        // Same, with clear in that gap cycle: queue emptied, the event leaves pending=1.
        t = cyc;
        expect_pulse(0, t + 3, 8);
        expect_pulse(0, t + 12, 8);
        expect_pulse(0, t + 22, 8);
        for (int k = 0; k < 5; k++) tap0(offs[k]);
        if0.i_clr[0] = 1'b1;
        step(1);
        if0.i_clr[0] = 1'b0;
        check("gap_clr_pulse", if0.o_pulse[0], 0);
        check("gap_clr_busy", if0.o_busy[0], 1);
        step(25);
        check("gap_clr_idle", if0.o_busy, 0);
        check("gap_clr_ovf", if0.o_ovf, 0);

        // Latency, both-edge mode, PULSE_W=3.
        t = cyc;
        expect_pulse(4, t + 3, 3);
        if1.i_a_sig[0] = 1'b1;
        step(2);
        check("lat_sync_lvl", if1.o_sync_lvl[0], 1);
        check("lat_pulse_pre", if1.o_pulse[0], 0);
        step(4);
        check("lat_gap_pulse", if1.o_pulse[0], 0);
        check("lat_gap_busy", if1.o_busy[0], 1);
        step(1);
        check("lat_idle", if1.o_busy[0], 0);
        step(1);
        if1.i_a_sig[0] = 1'b0;
        expect_pulse(4, cyc + 3, 3);
        step(10);

        // All four channels toggled together: two pulses per toggle pair, same cycles.
        t = cyc;
        for (int c = 0; c < 4; c++) begin
            expect_pulse(4 + c, t + 3, 3);
            expect_pulse(4 + c, t + 7, 3);
            expect_pulse(4 + c, t + 15, 3);
            expect_pulse(4 + c, t + 19, 3);
        end
        if1.i_a_sig = 4'hF;
        step(2);
        if1.i_a_sig = 4'h0;
        step(10);
        if1.i_a_sig = 4'hF;
        step(2);
        if1.i_a_sig = 4'h0;
        step(15);
        check("both_idle", if1.o_busy, 0);

        // Overflow: 10 edges during one 64-cycle pulse -> 8 pulses, sticky ovf.
        t = cyc;
        for (int k = 0; k < 8; k++) expect_pulse(8, t + 3 + 65 * k, 64);
        for (int k = 0; k < 10; k++) begin
            if2.i_a_sig[0] = 1'b1;
            step(2);
            if2.i_a_sig[0] = 1'b0;
            step(2);
        end
        check("ovf_set", if2.o_ovf, 1);
        step(490);
        check("ovf_sticky", if2.o_ovf, 1);
        check("ovf_idle", if2.o_busy, 0);
        if2.i_clr[0] = 1'b1;
        step(1);
        if2.i_clr[0] = 1'b0;
        check("ovf_clr", if2.o_ovf, 0);

        // Clear during an active pulse drops the queue but lets the pulse finish.
        t = cyc;
        expect_pulse(8, t + 3, 64);
        for (int k = 0; k < 3; k++) begin
            if2.i_a_sig[0] = 1'b1;
            step(2);
            if2.i_a_sig[0] = 1'b0;
            step(2);
        end
        if2.i_clr[0] = 1'b1;
        step(1);
        if2.i_clr[0] = 1'b0;
        check("clr_pulse_on", if2.o_pulse, 1);
        check("clr_ovf", if2.o_ovf, 0);
        step(60);
        check("clr_idle", if2.o_busy, 0);

        step(5);
        for (int b = 0; b < 9; b++) begin
            cnt = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].lane == b) cnt++;
            end
            check($sformatf("missing_pulses_l%0d", b), cnt, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
